// File: rtl/spi_slave_xfer_if.sv
// Client-side bus of the SPI responder: TX staging handshake, RX strobe and status.
interface spi_slave_xfer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              underrun;
    logic              frame_err;
    logic              busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, underrun, frame_err, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_xfer.sv
// SPI mode-0 responder: oversamples the SPI pins, shifts a staged word out on MISO
// and captures MOSI, with multi-word frames inside one CSN-low window.
module spi_slave_xfer #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    spi_slave_xfer_if.slave bus,
    input  logic            SPI_sclk,
    input  logic            SPI_csn,
    input  logic            SPI_mosi,
    output logic            SPI_miso,
    output logic            SPI_miso_oe
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] csn_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_d_reg;
    logic                   csn_d_reg;

    logic [1:0]        state_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              underrun_reg;
    logic              frame_err_reg;
    logic              miso_reg;
    logic              miso_oe_reg;

    logic sclk_s, csn_s, mosi_s;
    logic sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic hold_write, load_fire;

    // Cleared csn sync flops mean a frame already in progress at reset release
    // never produces a falling edge, so the FSM waits for a fresh select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            csn_sync_reg  <= '0;
            mosi_sync_reg <= '0;
            sclk_d_reg    <= 1'b0;
            csn_d_reg     <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SPI_sclk};
            csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], SPI_csn};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], SPI_mosi};
            sclk_d_reg    <= sclk_s;
            csn_d_reg     <= csn_s;
        end
    end

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign csn_s     = csn_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign csn_fall  = ~csn_s & csn_d_reg;
    assign csn_rise  = csn_s & ~csn_d_reg;

    assign hold_write = bus.tx_valid & ~hold_full_reg;
    assign load_fire  = (state_reg == LOAD) & ~csn_rise & hold_full_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else if (hold_write) begin
            hold_reg      <= bus.tx_data;
            hold_full_reg <= 1'b1;
        end else if (load_fire) begin
            hold_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            bit_cnt_reg   <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            miso_oe_reg   <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    miso_oe_reg <= 1'b0;
                    if (csn_fall) state_reg <= LOAD;
                end
                LOAD: begin
                    if (csn_rise) begin
                        miso_oe_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        tx_shift_reg <= hold_full_reg ? hold_reg : '0;
                        underrun_reg <= ~hold_full_reg;
                        bit_cnt_reg  <= '0;
                        miso_oe_reg  <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        miso_oe_reg <= 1'b0;
                        state_reg   <= IDLE;
                        if (bit_cnt_reg != '0 && bit_cnt_reg != CNT_FULL)
                            frame_err_reg <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
                        bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
                        if (bit_cnt_reg == CNT_LAST) begin
                            rx_data_reg  <= {rx_shift_reg[DATA_W-2:0], mosi_s};
                            rx_valid_reg <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_reg == CNT_FULL)
                            state_reg <= LOAD;
                        else
                            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    miso_oe_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) miso_reg <= 1'b0;
        else     miso_reg <= tx_shift_reg[DATA_W-1];
    end

    assign bus.tx_ready  = ~hold_full_reg;
    assign bus.rx_data   = rx_data_reg;
    assign bus.rx_valid  = rx_valid_reg;
    assign bus.underrun  = underrun_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign SPI_miso      = miso_reg;
    assign SPI_miso_oe   = miso_oe_reg;
endmodule

// File: tb/tb_spi_slave_xfer.sv
// Directed and randomized bench for spi_slave_xfer acting as a mode-0 SPI master.
module tb_spi_slave_xfer;
    localparam int HALF = 50;

    logic clk, rst;
    logic sclk, csn, mosi;
    logic miso, miso_oe;

    spi_slave_xfer_if #(.DATA_W(8)) bus ();

    spi_slave_xfer #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .SPI_sclk(sclk), .SPI_csn(csn), .SPI_mosi(mosi),
        .SPI_miso(miso), .SPI_miso_oe(miso_oe)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_log[$];
    int urun_cnt = 0;
    int ferr_cnt = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Holds tx_valid with the queue head until the DUT takes it.
    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.tx_valid && bus.tx_ready && tx_q.size() > 0) void'(tx_q.pop_front());
            #1;
            if (tx_q.size() > 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = tx_q[0];
            end else begin
                bus.tx_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid)  rx_log.push_back(bus.rx_data);
            if (bus.underrun)  urun_cnt++;
            if (bus.frame_err) ferr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_log.size() > 0) got = rx_log.pop_front();
        check(tag, {24'h0, got}, {24'h0, exp});
    endtask

    task automatic wait_q(input int target, input string tag);
        for (int i = 0; i < 100 && tx_q.size() != target; i++) @(negedge clk);
        check(tag, tx_q.size(), target);
    endtask

    // One word; the last word of a frame raises CSN together with the final SCLK fall.
    task automatic xfer_word(input logic [7:0] mo, input logic [7:0] exp_mi,
                             input bit last, input string tag);
        logic [7:0] mi;
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            #HALF;
            mi[i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
            if (last && i == 0) csn = 1'b1;
        end
        check(tag, {24'h0, mi}, {24'h0, exp_mi});
    endtask

    task automatic partial(input logic [7:0] mo, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, bus.tx_ready, 1);
        check({tag, "_rx_data"}, bus.rx_data, 0);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
        check({tag, "_underrun"}, bus.underrun, 0);
        check({tag, "_frame_err"}, bus.frame_err, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_miso"}, miso, 0);
        check({tag, "_miso_oe"}, miso_oe, 0);
    endtask

    initial begin
        int u0, f0, n, m;
        logic [7:0] w[3];
        logic [7:0] mo[3];
        sclk = 0; csn = 1; mosi = 0; rst = 1;
        #20;
        check_reset_outputs("rst");
        rst = 0;
        #100;

        // Single word
        tx_q.push_back(8'hA5);
        wait_q(0, "t1_stage");
        check("t1_ready_low", bus.tx_ready, 0);
        u0 = urun_cnt; f0 = ferr_cnt;
        csn = 0;
        xfer_word(8'h3C, 8'hA5, 1, "t1_miso");
        #200;
        check("t1_rx_count", rx_log.size(), 1);
        check_rx("t1_rx", 8'h3C);
        check("t1_ready", bus.tx_ready, 1);
        check("t1_underrun", urun_cnt - u0, 0);
        check("t1_frame_err", ferr_cnt - f0, 0);
        check("t1_busy", bus.busy, 0);
        check("t1_oe", miso_oe, 0);

        // Two words in one frame
        tx_q.push_back(8'h81);
        tx_q.push_back(8'h7E);
        wait_q(1, "t2_stage");
        u0 = urun_cnt;
        csn = 0;
        xfer_word(8'h11, 8'h81, 0, "t2_miso0");
        xfer_word(8'h22, 8'h7E, 1, "t2_miso1");
        #200;
        check("t2_rx_count", rx_log.size(), 2);
        check_rx("t2_rx0", 8'h11);
        check_rx("t2_rx1", 8'h22);
        check("t2_underrun", urun_cnt - u0, 0);
        check("t2_q_empty", tx_q.size(), 0);

        // Underrun
        u0 = urun_cnt;
        csn = 0;
        xfer_word(8'hFF, 8'h00, 1, "t3_miso");
        #200;
        check("t3_underrun", urun_cnt - u0, 1);
        check_rx("t3_rx", 8'hFF);

        // Abort after 5 rising edges
        f0 = ferr_cnt;
        csn = 0;
        partial(8'h96, 5);
        check("t4_busy_mid", bus.busy, 1);
        check("t4_oe_mid", miso_oe, 1);
        #HALF;
        csn = 1;
        #200;
        check("t4_frame_err", ferr_cnt - f0, 1);
        check("t4_no_rx", rx_log.size(), 0);
        check("t4_rx_hold", bus.rx_data, 8'hFF);
        check("t4_busy", bus.busy, 0);
        check("t4_oe", miso_oe, 0);

        // Backpressure
        u0 = urun_cnt;
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        wait_q(1, "t5_first");
        #300;
        check("t5_second_waiting", tx_q.size(), 1);
        check("t5_ready_low", bus.tx_ready, 0);
        csn = 0;
        xfer_word(8'hAA, 8'h01, 1, "t5_miso0");
        #200;
        check("t5_second_taken", tx_q.size(), 0);
        check("t5_ready_full", bus.tx_ready, 0);
        csn = 0;
        xfer_word(8'h55, 8'h02, 1, "t5_miso1");
        #200;
        check("t5_underrun", urun_cnt - u0, 0);
        check_rx("t5_rx0", 8'hAA);
        check_rx("t5_rx1", 8'h55);

        // Reset mid-frame
        u0 = urun_cnt; f0 = ferr_cnt;
        csn = 0;
        partial(8'hF0, 3);
        rst = 1;
        #1;
        check_reset_outputs("t6_async");
        #49;
        rst = 0;
        #200;
        check("t6_no_resync", bus.busy, 0);
        csn = 1;
        #200;
        check("t6_frame_err", ferr_cnt - f0, 0);
        check("t6_no_rx", rx_log.size(), 0);
        tx_q.push_back(8'h5A);
        wait_q(0, "t6_stage");
        csn = 0;
        xfer_word(8'hC3, 8'h5A, 1, "t6_miso");
        #200;
        check_rx("t6_rx", 8'hC3);
        check("t6_underrun", urun_cnt - u0, 1);

        // Random frames: the first m of n words are staged, the rest underrun
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 3);
            m = $urandom_range(0, n);
            for (int k = 0; k < 3; k++) begin
                w[k]  = 8'($urandom);
                mo[k] = 8'($urandom);
            end
            for (int k = 0; k < m; k++) tx_q.push_back(w[k]);
            if (m > 0) wait_q(m - 1, "rnd_stage");
            u0 = urun_cnt; f0 = ferr_cnt;
            csn = 0;
            for (int k = 0; k < n; k++)
                xfer_word(mo[k], (k < m) ? w[k] : 8'h00, k == n - 1, "rnd_miso");
            #200;
            check("rnd_underrun", urun_cnt - u0, n - m);
            check("rnd_frame_err", ferr_cnt - f0, 0);
            check("rnd_rx_count", rx_log.size(), n);
            for (int k = 0; k < n; k++) check_rx("rnd_rx", mo[k]);
            check("rnd_q_empty", tx_q.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
